ps2_kbd_frame_rx: RTL

//  Upstream stage of the console keyboard path. Takes raw PS/2 keyboard clock/data from hps_io
//  (ps2_kbd_clk_out / ps2_kbd_data_out), filters them, and deframes 11-bit PS/2 frames.

---
 rtl/ps2_kbd_frame_rx.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_frame_rx.sv
// ps2_kbd_frame_rx
//   Receives raw PS/2 keyboard clock/data, filters them, deframes 11-bit
//   frames (start, 8 data LSB first, odd parity, stop) and queues good
//   scancodes in a small first-word-fall-through FIFO. The FIFO is read
//   over a valid/ready handshake.
//
// Ports
//   clk_sys     system clock, every register lives in this domain
//   rst_n       asynchronous active-low reset
//   ps2_clk     raw PS/2 clock (idle high, asynchronous)
//   ps2_data    raw PS/2 data  (idle high, asynchronous)
//   code_data   scancode at the FIFO head (0 while empty)
//   code_valid  FIFO holds at least one scancode
//   code_ready  consumer takes the head when high together with code_valid
//   frame_err   one-cycle pulse on start/parity/stop/timeout error
//   overflow    one-cycle pulse when a good byte is dropped on a full FIFO
//   fifo_level  number of queued scancodes, 0..FIFO_DEPTH
module ps2_kbd_frame_rx #(
  parameter int CLK_HZ     = 100000000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_sys,
  input  logic                          rst_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    code_data,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int FCW         = $clog2(FILTER_LEN);
  localparam int TCW         = $clog2(TIMEOUT_CYC + 1);
  localparam int AW          = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic [1:0]     clk_sync;
  logic [1:0]     data_sync;
  logic           data_s;
  logic           filt_clk;
  logic [FCW-1:0] filt_cnt;
  logic           fe;

  state_t         state_q;
  state_t         state_d;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift_q;
  logic           par_q;
  logic [TCW-1:0] to_cnt;
  logic           timeout_hit;
  logic           err_d;
  logic           push;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           full;
  logic           pop;
  logic           do_push;
  logic           overflow_d;

  assign data_s = data_sync[1];

  // Two-flop synchronisers; reset to the PS/2 idle level so that release
  // from reset never looks like a falling clock edge.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Glitch filter: the filtered clock only follows the synced clock once the
  // new level has been seen on FILTER_LEN consecutive samples. Any sample
  // equal to the current filtered level restarts the run. fe is a one-cycle
  // strobe issued when the filtered clock drops from 1 to 0.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fe       <= 1'b0;
    end else begin
      fe <= 1'b0;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
        fe       <= filt_clk;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Inter-edge watchdog: cleared by every falling edge, idle in ST_IDLE,
  // saturates at the limit so a stuck bus cannot wrap it.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (fe || state_q == ST_IDLE) begin
      to_cnt <= '0;
    end else if (to_cnt != TCW'(TIMEOUT_CYC)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state_q != ST_IDLE) && (to_cnt == TCW'(TIMEOUT_CYC));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame sequencer. A timeout wins over a coincident edge so that a frame
  // that has already exceeded its gap budget is always discarded.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    push    = 1'b0;
    if (timeout_hit) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end else if (fe) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d = ST_DATA;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_cnt == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (data_s && (^{shift_q, par_q})) begin
            push = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Bit collection: data arrives LSB first, so shift in from the top.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else if (fe && !timeout_hit) begin
      case (state_q)
        ST_IDLE: begin
          bit_cnt <= '0;
        end
        ST_DATA: begin
          shift_q <= {data_s, shift_q[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        ST_PARITY: begin
          par_q <= data_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign full       = (count == (AW + 1)'(FIFO_DEPTH));
  assign code_valid = (count != '0);
  assign pop        = code_valid && code_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign do_push    = push && (!full || pop);
  assign overflow_d = push && full && !pop;
  assign code_data  = code_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_level = count;

  // Storage needs no reset; the head is masked to zero while empty.
  always_ff @(posedge clk_sys) begin
    if (do_push) begin
      mem[wr_ptr] <= shift_q;
    end
  end

  // Pointers rely on the power-of-two depth to wrap naturally.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= err_d;
      overflow  <= overflow_d;
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
